// File: rtl/fp_alu_seq.sv
// fp_alu_seq: multi-cycle single-precision FP ALU (add/sub/mul/div) with a start/done handshake.
// Optional divider: define FP_ALU_DIV_EN to build the DIV state and restoring divider.
// Without it, ALU_Op=11 completes immediately with a +0 result.
module fp_alu_seq #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned MANT_W    = 23,
  parameter int unsigned EXP_W     = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [1:0]           ALU_Op,
  input  logic [DATAWIDTH-1:0] data_iA,
  input  logic [DATAWIDTH-1:0] data_iB,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 flg_negative,
  output logic                 flg_zero,
  output logic                 flg_overflow,
  output logic                 flg_div0,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned SGN    = DATAWIDTH - 1;
  localparam int unsigned EXP_LO = MANT_W;
  localparam int unsigned EXP_HI = MANT_W + EXP_W - 1;
  localparam int unsigned MAN_W  = MANT_W + 1;      // mantissa with hidden bit
  localparam int unsigned AS_W   = MANT_W + 4;      // carry + hidden + mantissa + 2 guard
  localparam int unsigned PROD_W = 2 * MAN_W;       // common normalisation frame
  localparam int unsigned QUO_W  = MANT_W + 3;      // quotient bits
  localparam int unsigned HID    = PROD_W - 2;      // hidden-bit position in the frame
  localparam int unsigned SH_MAX = AS_W - 1;        // alignment / normalisation bound
  localparam int unsigned E_W    = 10;
  localparam int unsigned CNT_W  = 5;

  localparam logic signed [E_W-1:0] BIAS    = 10'sd127;
  localparam logic signed [E_W-1:0] EXP_INF = 10'sd255;
  localparam logic signed [E_W-1:0] EXP_ONE = 10'sd1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
`ifdef FP_ALU_DIV_EN
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [DATAWIDTH-1:0] QNAN = 32'h7FC00000;
`endif

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, MUL, DIV, NORM, PACK} state_t;

  state_t state, state_nx;

  logic [1:0]            op_q;
  logic [DATAWIDTH-1:0]  a_q, b_q;
  logic                  sa, sb, rs;
  logic signed [E_W-1:0] ea, eb, re;
  logic [AS_W-1:0]       am, bm;
  logic [PROD_W-1:0]     man;
  logic [CNT_W-1:0]      cnt;
  logic                  byp, byp_div0;
  logic [DATAWIDTH-1:0]  byp_word;
`ifdef FP_ALU_DIV_EN
  logic [QUO_W-1:0]      rem;
  logic [QUO_W-1:0]      trial_c, rem_keep_c;
  logic                  qbit_c;
`endif

  logic                  za_c, zb_c, sb_eff_c, sres_c;
  logic signed [E_W-1:0] ea_raw_c, eb_raw_c, ediff_c;
  logic [E_W-1:0]        abs_c;
  logic [CNT_W-1:0]      shamt_c;
  logic                  byp_c, byp_div0_c;
  logic [DATAWIDTH-1:0]  byp_word_c;
  logic [AS_W-1:0]       sum_c;
  logic                  sum_s_c;
  logic [MAN_W:0]        mul_sum_c;
  logic                  norm_ok_c;
  logic [DATAWIDTH-1:0]  pack_word_c;
  logic                  pack_ovf_c, pack_div0_c;

  // Operand field decode from the captured request
  assign za_c     = (a_q[EXP_HI:EXP_LO] == '0);
  assign zb_c     = (b_q[EXP_HI:EXP_LO] == '0);
  assign sb_eff_c = b_q[SGN] ^ (op_q == OP_SUB);
  assign sres_c   = a_q[SGN] ^ b_q[SGN];
  assign ea_raw_c = {2'b00, a_q[EXP_HI:EXP_LO]};
  assign eb_raw_c = {2'b00, b_q[EXP_HI:EXP_LO]};

  // Zero / divide-by-zero shortcuts that skip the arithmetic states
  always_comb begin
    byp_c      = 1'b0;
    byp_word_c = '0;
    byp_div0_c = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        if (zb_c) begin
          byp_c      = 1'b1;
          byp_word_c = {a_q[SGN], za_c ? {(DATAWIDTH-1){1'b0}} : a_q[SGN-1:0]};
        end else if (za_c) begin
          byp_c      = 1'b1;
          byp_word_c = {sb_eff_c, b_q[SGN-1:0]};
        end
      end
      OP_MUL: begin
        if (za_c || zb_c) begin
          byp_c      = 1'b1;
          byp_word_c = {sres_c, {(DATAWIDTH-1){1'b0}}};
        end
      end
      default: begin
`ifdef FP_ALU_DIV_EN
        if (zb_c) begin
          byp_c      = 1'b1;
          byp_div0_c = 1'b1;
          byp_word_c = za_c ? QNAN : {sres_c, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (za_c) begin
          byp_c      = 1'b1;
          byp_word_c = {sres_c, {(DATAWIDTH-1){1'b0}}};
        end
`else
        byp_c = 1'b1;
`endif
      end
    endcase
  end

  // Alignment shift amount, saturated
  assign ediff_c = ea - eb;
  assign abs_c   = ediff_c[E_W-1] ? -ediff_c : ediff_c;
  assign shamt_c = (abs_c > E_W'(SH_MAX)) ? CNT_W'(SH_MAX) : abs_c[CNT_W-1:0];

  // Signed-magnitude add/subtract of aligned mantissas
  always_comb begin
    sum_c   = '0;
    sum_s_c = sa;
    if (sa == sb) begin
      sum_c = am + bm;
    end else if (am >= bm) begin
      sum_c = am - bm;
    end else begin
      sum_c   = bm - am;
      sum_s_c = sb;
    end
  end

  // One shift-add multiply step: conditional add into the upper half
  assign mul_sum_c = {1'b0, man[PROD_W-1:MAN_W]} + (man[0] ? {1'b0, am[AS_W-2:2]} : '0);

`ifdef FP_ALU_DIV_EN
  // One restoring-division step
  assign trial_c    = rem - {2'b00, bm[AS_W-2:2]};
  assign qbit_c     = ~trial_c[QUO_W-1];
  assign rem_keep_c = qbit_c ? trial_c : rem;
`endif

  assign norm_ok_c = (~man[PROD_W-1] & man[HID]) | (cnt == CNT_W'(SH_MAX));

  // Final packing with saturation to infinity or flush to zero
  always_comb begin
    pack_word_c = {rs, re[EXP_W-1:0], man[HID-1 -: MANT_W]};
    pack_ovf_c  = 1'b0;
    pack_div0_c = 1'b0;
    if (byp) begin
      pack_word_c = byp_word;
      pack_div0_c = byp_div0;
    end else if (re >= EXP_INF) begin
      pack_word_c = {rs, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      pack_ovf_c  = 1'b1;
    end else if (re <= 10'sd0) begin
      pack_word_c = {rs, {(DATAWIDTH-1){1'b0}}};
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = UNPACK;
      UNPACK: begin
        if (byp_c)                 state_nx = PACK;
        else if (op_q == OP_MUL)   state_nx = MUL;
`ifdef FP_ALU_DIV_EN
        else if (op_q == OP_DIV)   state_nx = DIV;
`endif
        else                       state_nx = ALIGN;
      end
      ALIGN:  state_nx = ADDSUB;
      ADDSUB: state_nx = (sum_c == '0) ? PACK : NORM;
      MUL:    if (cnt == CNT_W'(MAN_W - 1)) state_nx = NORM;
`ifdef FP_ALU_DIV_EN
      DIV:    if (cnt == CNT_W'(QUO_W - 1)) state_nx = NORM;
`endif
      NORM:   if (norm_ok_c) state_nx = PACK;
      PACK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs: result/flags at PACK, done pulse, busy window
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_o       <= '0;
      flg_negative <= 1'b0;
      flg_zero     <= 1'b0;
      flg_overflow <= 1'b0;
      flg_div0     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nx != IDLE) || (state == PACK);
      if (state == PACK) begin
        data_o       <= pack_word_c;
        flg_negative <= pack_word_c[SGN];
        flg_zero     <= (pack_word_c[SGN-1:0] == '0);
        flg_overflow <= pack_ovf_c;
        flg_div0     <= pack_div0_c;
        done         <= 1'b1;
      end
    end
  end

  // Datapath registers, advanced per state
  always_ff @(posedge Clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          op_q <= ALU_Op;
          a_q  <= data_iA;
          b_q  <= data_iB;
        end
      end
      UNPACK: begin
        sa       <= a_q[SGN];
        sb       <= sb_eff_c;
        ea       <= ea_raw_c;
        eb       <= eb_raw_c;
        am       <= za_c ? '0 : {1'b0, 1'b1, a_q[MANT_W-1:0], 2'b00};
        bm       <= zb_c ? '0 : {1'b0, 1'b1, b_q[MANT_W-1:0], 2'b00};
        rs       <= sres_c;
        re       <= (op_q == OP_MUL) ? (ea_raw_c + eb_raw_c - BIAS) : (ea_raw_c - eb_raw_c + BIAS);
        man      <= {{MAN_W{1'b0}}, 1'b1, b_q[MANT_W-1:0]};
        cnt      <= '0;
        byp      <= byp_c;
        byp_word <= byp_word_c;
        byp_div0 <= byp_div0_c;
`ifdef FP_ALU_DIV_EN
        rem      <= {2'b00, 1'b1, a_q[MANT_W-1:0]};
`endif
      end
      ALIGN: begin
        if (!ediff_c[E_W-1]) begin
          bm <= bm >> shamt_c;
          re <= ea;
        end else begin
          am <= am >> shamt_c;
          re <= eb;
        end
      end
      ADDSUB: begin
        cnt <= '0;
        if (sum_c == '0) begin
          byp      <= 1'b1;
          byp_word <= '0;
          byp_div0 <= 1'b0;
        end else begin
          man <= {sum_c, {(PROD_W-AS_W){1'b0}}};
          rs  <= sum_s_c;
        end
      end
      MUL: begin
        man <= {mul_sum_c, man[MAN_W-1:1]};
        cnt <= (cnt == CNT_W'(MAN_W - 1)) ? '0 : cnt + 1'b1;
      end
`ifdef FP_ALU_DIV_EN
      DIV: begin
        rem <= {rem_keep_c[QUO_W-2:0], 1'b0};
        if (cnt == CNT_W'(QUO_W - 1)) begin
          man <= {1'b0, man[QUO_W-2:0], qbit_c, {(PROD_W-QUO_W-1){1'b0}}};
          cnt <= '0;
        end else begin
          man <= {man[PROD_W-2:0], qbit_c};
          cnt <= cnt + 1'b1;
        end
      end
`endif
      NORM: begin
        if (!norm_ok_c) begin
          cnt <= cnt + 1'b1;
          if (man[PROD_W-1]) begin
            man <= man >> 1;
            re  <= re + EXP_ONE;
          end else begin
            man <= man << 1;
            re  <= re - EXP_ONE;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_alu_seq.sv
// tb_fp_alu_seq: directed and randomised checks of fp_alu_seq against a behavioural FP model.
module tb_fp_alu_seq;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [1:0]  ALU_Op;
  logic [31:0] data_iA, data_iB, data_o;
  logic        flg_negative, flg_zero, flg_overflow, flg_div0, busy, done;

  int n_chk = 0;
  int n_bad = 0;

  localparam longint TWO25 = 64'sd33554432;
  localparam longint TWO26 = 64'sd67108864;

  fp_alu_seq dut (
    .Clk(Clk), .Rst(Rst), .start(start), .ALU_Op(ALU_Op),
    .data_iA(data_iA), .data_iB(data_iB), .data_o(data_o),
    .flg_negative(flg_negative), .flg_zero(flg_zero), .flg_overflow(flg_overflow),
    .flg_div0(flg_div0), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // {div0, ovf, word}
  function automatic logic [33:0] fp_pack(input logic s, input int e, input logic [22:0] m);
    if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b00, s, 31'd0};
    return {2'b00, s, 8'(e), m};
  endfunction

  // Behavioural reference: exact integer arithmetic, truncation, flush-to-zero
  function automatic logic [33:0] fp_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sp, za, zb;
    int ea, eb, e, sh;
    longint va, vb, v, mag;
    logic [63:0] tmp;
    sa = a[31];
    sb = b[31] ^ (op == 2'b01);
    sp = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    va = longint'({1'b1, a[22:0]});
    vb = longint'({1'b1, b[22:0]});
    case (op)
      2'b00, 2'b01: begin
        if (zb) return {2'b00, a[31], za ? 31'd0 : a[30:0]};
        if (za) return {2'b00, sb, b[30:0]};
        va = va * 4;
        vb = vb * 4;
        if (ea >= eb) begin
          sh = ea - eb; if (sh > 26) sh = 26;
          vb = vb >> sh; e = ea;
        end else begin
          sh = eb - ea; if (sh > 26) sh = 26;
          va = va >> sh; e = eb;
        end
        v = (sa ? -va : va) + (sb ? -vb : vb);
        if (v == 0) return 34'd0;
        mag = (v < 0) ? -v : v;
        while (mag >= TWO26) begin mag = mag >> 1; e++; end
        while (mag < TWO25)  begin mag = mag << 1; e--; end
        tmp = 64'(mag);
        return fp_pack(v < 0, e, tmp[24:2]);
      end
      2'b10: begin
        if (za || zb) return {2'b00, sp, 31'd0};
        tmp = 64'(va * vb);
        e = ea + eb - 127;
        if (tmp[47]) begin tmp = tmp >> 1; e++; end
        return fp_pack(sp, e, tmp[45:23]);
      end
      default: begin
`ifdef FP_ALU_DIV_EN
        if (zb) return za ? {2'b10, 32'h7FC00000} : {2'b10, sp, 8'hFF, 23'd0};
        if (za) return {2'b00, sp, 31'd0};
        tmp = 64'((va << 25) / vb);
        e = ea - eb + 127;
        if (!tmp[25]) begin tmp = tmp << 1; e--; end
        return fp_pack(sp, e, tmp[24:2]);
`else
        return 34'd0;
`endif
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(1, 254));
    if ($urandom_range(0, 15) == 0) r[30:23] = 8'd0;
    return r;
  endfunction

  // One transaction: start, wait (bounded) for done, compare result, flags and pulse shape
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [33:0] exp_r, input string tag);
    int cyc;
    @(negedge Clk);
    start = 1'b1; ALU_Op = op; data_iA = a; data_iB = b;
    @(negedge Clk);
    start = 1'b0; ALU_Op = 2'($urandom); data_iA = $urandom; data_iB = $urandom;
    cyc = 0;
    while (!done && cyc < 80) begin
      @(negedge Clk);
      cyc++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_data"}, data_o, exp_r[31:0]);
      chk({tag, "_flags"}, {28'd0, flg_negative, flg_zero, flg_overflow, flg_div0},
          {28'd0, exp_r[31], exp_r[30:0] == 31'd0, exp_r[32], exp_r[33]});
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
      @(negedge Clk);
      chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a, b, got;
    logic [1:0]  op, rst_op;
    logic [33:0] rst_exp;
    int          ndone;
    logic        busy_drop, early, late;

    Rst = 1'b1; start = 1'b0; ALU_Op = 2'b00; data_iA = '0; data_iB = '0;
    repeat (3) @(negedge Clk);
    chk("reset_data", data_o, 32'd0);
    chk("reset_ctrl", {26'd0, flg_negative, flg_zero, flg_overflow, flg_div0, busy, done}, 32'd0);
    Rst = 1'b0;

    run_op(2'b00, 32'hBFA00000, 32'h3FA00000, {2'b00, 32'h00000000}, "add_cancel");
    run_op(2'b01, 32'hBFA00000, 32'h3FA00000, {2'b00, 32'hC0200000}, "sub_neg");
    run_op(2'b10, 32'hBFA00000, 32'h3FA00000, {2'b00, 32'hBFC80000}, "mul_basic");
`ifdef FP_ALU_DIV_EN
    run_op(2'b11, 32'hBFA00000, 32'h3FA00000, {2'b00, 32'hBF800000}, "div_basic");
    run_op(2'b11, 32'h3F800000, 32'h00000000, {2'b10, 32'h7F800000}, "div_by0");
    run_op(2'b11, 32'h00000000, 32'h00000000, {2'b10, 32'h7FC00000}, "div_0by0");
`else
    run_op(2'b11, 32'hBFA00000, 32'h3FA00000, {2'b00, 32'h00000000}, "div_off");
`endif
    run_op(2'b10, 32'h7F000000, 32'h40000000, {2'b01, 32'h7F800000}, "mul_ovf");
    run_op(2'b10, 32'h00800000, 32'h3F000000, {2'b00, 32'h00000000}, "mul_unf");
    run_op(2'b01, 32'h3F800001, 32'h3F800000, {2'b00, 32'h34000000}, "sub_deep_norm");
    run_op(2'b00, 32'h3F800000, 32'h00000000, {2'b00, 32'h3F800000}, "add_zero_b");
    run_op(2'b01, 32'h00000000, 32'h3F800000, {2'b00, 32'hBF800000}, "sub_zero_a");
    run_op(2'b00, 32'h4B800000, 32'h3F800000, {2'b00, 32'h4B800000}, "add_far_trunc");

    // A second start during a multiply is ignored and not queued
    @(negedge Clk);
    start = 1'b1; ALU_Op = 2'b10; data_iA = 32'hBFA00000; data_iB = 32'h3FA00000;
    @(negedge Clk);
    start = 1'b0;
    ndone = 0; busy_drop = 1'b0; got = '0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 3) begin
        start = 1'b1; ALU_Op = 2'b00; data_iA = 32'h40000000; data_iB = 32'h40400000;
      end else begin
        start = 1'b0;
      end
      @(negedge Clk);
      if (done) begin
        ndone++;
        got = data_o;
        if (!busy) busy_drop = 1'b1;
      end else if (ndone == 0 && !busy) begin
        busy_drop = 1'b1;
      end
    end
    chk("restart_ndone", 32'(ndone), 32'd1);
    chk("restart_data", got, 32'hBFC80000);
    chk("restart_busy_hold", {31'd0, busy_drop}, 32'd0);
    chk("restart_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a long operation aborts it silently
`ifdef FP_ALU_DIV_EN
    rst_op = 2'b11; rst_exp = {2'b00, 32'h40000000};
`else
    rst_op = 2'b10; rst_exp = {2'b00, 32'h40900000};
`endif
    @(negedge Clk);
    start = 1'b1; ALU_Op = rst_op; data_iA = 32'h40400000; data_iB = 32'h3FC00000;
    @(negedge Clk);
    start = 1'b0;
    early = 1'b0;
    repeat (9) begin
      @(negedge Clk);
      if (done) early = 1'b1;
    end
    Rst = 1'b1;
    @(negedge Clk);
    chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("midrst_data", data_o, 32'd0);
    Rst = 1'b0;
    late = 1'b0;
    repeat (70) begin
      @(negedge Clk);
      if (done) late = 1'b1;
    end
    chk("midrst_nodone", {30'd0, early, late}, 32'd0);
    run_op(rst_op, 32'h40400000, 32'h3FC00000, rst_exp, "after_rst");

    // Randomised operations against the reference model
    for (int k = 0; k < 300; k++) begin
      op = 2'($urandom);
      a  = rnd_fp();
      b  = rnd_fp();
      if (op[1] == 1'b0 && $urandom_range(0, 1) == 1) b[30:23] = a[30:23];
      if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0] ^ 23'($urandom_range(0, 15));
      run_op(op, a, b, fp_ref(op, a, b), "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
